// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter: round-robin arbiter sharing the single GPR write port among NREQ writeback requesters.
// The registered winner drives the write port and doubles as the forwarding source for read stages.
module gpr_wr_arbiter #(
    parameter int N    = 32,
    parameter int Nreg = 32,
    parameter int K    = $clog2(Nreg),
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*K-1:0] req_addr,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wren,
    output logic [K-1:0]      write_port_address,
    output logic [N-1:0]      d,
    output logic              byp_valid,
    output logic [K-1:0]      byp_addr,
    output logic [N-1:0]      byp_data
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr, g;
    logic          hit;
    int            idx;

    // Scan from ptr upward with an explicit modulo so non-power-of-two NREQ wraps correctly.
    always_comb begin
        g   = '0;
        hit = 1'b0;
        idx = 0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (int'(ptr) + j) % NREQ;
            if (!hit && req_valid[idx[PW-1:0]]) begin
                hit = 1'b1;
                g   = idx[PW-1:0];
            end
        end
    end

    assign req_ready = (hit && rst) ? NREQ'(1) << g : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr                <= '0;
            wren               <= 1'b0;
            write_port_address <= '0;
            d                  <= '0;
        end else if (hit) begin
            wren               <= req_addr[g*K +: K] != '0;
            write_port_address <= req_addr[g*K +: K];
            d                  <= req_data[g*N +: N];
            ptr                <= int'(g) == NREQ - 1 ? '0 : g + 1'b1;
        end else begin
            wren <= 1'b0;
        end
    end

    assign byp_valid = wren;
    assign byp_addr  = write_port_address;
    assign byp_data  = d;
endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// tb_gpr_wr_arbiter: randomized and directed checks of the arbiter (NREQ=3) against a behavioural model.
module tb_gpr_wr_arbiter;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [14:0]   req_addr = '0;
    logic [95:0]   req_data = '0;
    logic [NR-1:0] req_ready;
    logic          wren, byp_valid;
    logic [4:0]    write_port_address, byp_addr;
    logic [31:0]   d, byp_data;

    gpr_wr_arbiter #(.N(32), .Nreg(32), .NREQ(NR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wren(wren), .write_port_address(write_port_address), .d(d),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          mptr = 0, mg = -1;
    logic        mw = 1'b0;
    logic [4:0]  ma = '0;
    logic [31:0] md = '0;
    logic [2:0]  exp_ready;
    logic [31:0] gpr [32] = '{default: 32'h0};
    logic [31:0] egpr[32] = '{default: 32'h0};

    always @(posedge clk) if (wren) gpr[write_port_address] <= d;

    function automatic int model_grant(input logic [2:0] v);
        for (int j = 0; j < NR; j++)
            if (v[(mptr + j) % NR]) return (mptr + j) % NR;
        return -1;
    endfunction

    task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [95:0] dt);
        req_valid = v;
        req_addr  = a;
        req_data  = dt;
        #1;
        mg        = model_grant(v);
        exp_ready = mg < 0 ? 3'b000 : 3'(1 << mg);
    endtask

    task automatic step();
        @(posedge clk);
        if (mw) egpr[ma] = md;
        if (mg >= 0) begin
            ma   = req_addr[mg*5 +: 5];
            md   = req_data[mg*32 +: 32];
            mw   = ma != 5'd0;
            mptr = (mg + 1) % NR;
        end else mw = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        mptr = 0; mw = 1'b0; ma = '0; md = '0; mg = -1;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        #3;
        checks++;
        if ({req_ready, wren, write_port_address, d, byp_valid, byp_addr, byp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b wren=%b addr=%0d d=%h byp=%b", req_ready, wren, write_port_address, d, byp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hA5A5_0001, 32'h0});
        checks++;
        if (req_ready !== 3'b010 || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL reset_first_grant got %b exp %b", req_ready, 3'b010);
        end
        step();
        checks++;
        if ({wren, write_port_address, d} !== {1'b1, 5'd7, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL reset_first_write got %b %0d %h", wren, write_port_address, d);
        end
    endtask

    task automatic test_contention();
        logic [4:0] seq [4];
        seq = '{5'd1, 5'd2, 5'd1, 5'd2};
        for (int c = 0; c < 4; c++) begin
            drive(3'b011, {5'd0, 5'd2, 5'd1}, {32'h0, 32'h2222_0000 + 32'(c), 32'h1111_0000 + 32'(c)});
            checks++;
            if (req_ready !== exp_ready || req_ready !== 3'(1 << (c % 2))) begin
                errors++;
                $display("FAIL contention_ready[%0d] got %b exp %b", c, req_ready, 3'(1 << (c % 2)));
            end
            step();
            checks++;
            if (wren !== 1'b1 || write_port_address !== seq[c] || {byp_valid, byp_addr, byp_data} !== {mw, ma, md} || d !== md) begin
                errors++;
                $display("FAIL contention_out[%0d] got wren=%b addr=%0d d=%h exp addr=%0d d=%h", c, wren, write_port_address, d, seq[c], md);
            end
        end
    endtask

    task automatic test_single();
        drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD_BEEF});
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL single_ready got %b exp 001", req_ready);
        end
        step();
        drive(3'b000, '0, '0);
        checks++;
        if ({wren, write_port_address, d} !== {1'b1, 5'd5, 32'hDEAD_BEEF} || {byp_valid, byp_addr, byp_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_out got %b %0d %h byp %b %0d %h", wren, write_port_address, d, byp_valid, byp_addr, byp_data);
        end
        step();
        checks++;
        if (wren !== 1'b0 || d !== 32'hDEAD_BEEF || gpr[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_after got wren=%b d=%h r5=%h", wren, d, gpr[5]);
        end
    endtask

    task automatic test_r0_drop();
        drive(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0000_1234, 32'h0});
        checks++;
        if (req_ready !== 3'b010 || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL r0_ready got %b exp 010", req_ready);
        end
        step();
        checks++;
        if (wren !== 1'b0 || byp_valid !== 1'b0 || d !== 32'h0000_1234) begin
            errors++;
            $display("FAIL r0_drop got wren=%b byp_valid=%b d=%h", wren, byp_valid, d);
        end
        drive(3'b101, {5'd3, 5'd0, 5'd4}, {32'h33, 32'h0, 32'h44});
        checks++;
        if (req_ready !== 3'b100 || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL r0_ptr_advance got %b exp 100", req_ready);
        end
        step();
    endtask

    task automatic test_wrap();
        drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0});
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL wrap_req2 got %b exp 100", req_ready);
        end
        step();
        drive(3'b110, {5'd10, 5'd11, 5'd0}, {32'hAA, 32'hBB, 32'h0});
        checks++;
        if (req_ready !== 3'b010 || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL wrap_req1_first got %b exp 010", req_ready);
        end
        step();
        drive(3'b100, {5'd10, 5'd11, 5'd0}, {32'hAA, 32'hBB, 32'h0});
        checks++;
        if (req_ready !== 3'b100 || {wren, write_port_address, d} !== {1'b1, 5'd11, 32'hBB}) begin
            errors++;
            $display("FAIL wrap_req2_next got ready=%b addr=%0d d=%h", req_ready, write_port_address, d);
        end
        step();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            drive(3'b000, '0, '0);
            step();
            checks++;
            if (wren !== 1'b0 || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL idle[%0d] got wren=%b ready=%b", c, wren, req_ready);
            end
        end
        drive(3'b111, {5'd21, 5'd22, 5'd23}, {32'h21, 32'h22, 32'h23});
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL idle_ptr_hold got %b exp %b", req_ready, exp_ready);
        end
        step();
        checks++;
        if ({wren, write_port_address, d} !== {mw, ma, md}) begin
            errors++;
            $display("FAIL idle_latency got %b %0d %h exp %b %0d %h", wren, write_port_address, d, mw, ma, md);
        end
    endtask

    task automatic test_reset_midstream();
        drive(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h9999_9999});
        step();
        checks++;
        if (wren !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got wren=%b exp 1", wren);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, wren, write_port_address, d, byp_valid, byp_addr, byp_data} !== '0) begin
            errors++;
            $display("FAIL midreset_async got ready=%b wren=%b addr=%0d d=%h", req_ready, wren, write_port_address, d);
        end
        model_reset();
        rst = 1'b1;
        drive(3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'h1212, 32'h0});
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL midreset_first_grant got %b exp 010", req_ready);
        end
        step();
    endtask

    task automatic test_random();
        logic        pv [NR];
        logic [4:0]  pa [NR];
        logic [31:0] pd [NR];
        int          wt [NR];
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] dt;
        for (int i = 0; i < NR; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; wt[i] = 0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pv[i] && $urandom_range(1, 0) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = $urandom_range(3, 0) == 0 ? 5'd0 : 5'($urandom_range(31, 0));
                    pd[i] = $urandom;
                end
            for (int i = 0; i < NR; i++) begin
                v[i] = pv[i];
                a[i*5 +: 5] = pa[i];
                dt[i*32 +: 32] = pd[i];
            end
            drive(v, a, dt);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %b exp %b valid %b", c, req_ready, exp_ready, v);
            end
            for (int i = 0; i < NR; i++)
                if (pv[i] && req_ready[i]) begin
                    checks++;
                    if (wt[i] > NR - 1) begin
                        errors++;
                        $display("FAIL rand_fair req%0d waited %0d grants max %0d", i, wt[i], NR - 1);
                    end
                    wt[i] = 0;
                end else if (pv[i] && req_ready != 0) wt[i]++;
            step();
            checks++;
            if ({wren, write_port_address, d, byp_valid, byp_addr, byp_data} !== {mw, ma, md, mw, ma, md}) begin
                errors++;
                $display("FAIL rand_out[%0d] got %b %0d %h exp %b %0d %h", c, wren, write_port_address, d, mw, ma, md);
            end
            if (mg >= 0) pv[mg] = 1'b0;
        end
        drive(3'b000, '0, '0);
        step();
        step();
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (gpr[r] !== egpr[r]) begin
                errors++;
                $display("FAIL rand_gpr r%0d got %h exp %h", r, gpr[r], egpr[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_r0_drop();
        test_wrap();
        test_idle();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
